// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register: occupancy encoding and bubble values.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam logic [31:0] PIPE_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/pipe_entry_reg.sv
// One {instr, pc, pc4} entry; bubble load wins over a normal load.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int                INSTR_W  = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PIPE_RESET_PC)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic               bubble_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [ADDR_W-1:0]  pc4_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc4_o
);

  localparam logic [ADDR_W-1:0] RESET_PC4 = RESET_PC + ADDR_W'(4);

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q, pc4_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instr_q <= INSTR_W'(NOP_INSTR);
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC4;
    end else if (bubble_i) begin
      instr_q <= INSTR_W'(NOP_INSTR);
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC4;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      pc4_q   <= pc4_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble,
// optional skid entry (registered in_ready) and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                INSTR_W  = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PIPE_RESET_PC),
  parameter bit                SKID     = 1'b1,
  parameter int                CNT_W    = 16
) (
  input  logic               pipe_clk_i,
  input  logic               pipe_rst_n_i,
  input  logic               pipe_flush_i,
  input  logic               pipe_in_valid_i,
  output logic               pipe_in_ready_o,
  input  logic [INSTR_W-1:0] pipe_instr_i,
  input  logic [ADDR_W-1:0]  pipe_pc_i,
  input  logic [ADDR_W-1:0]  pipe_pc4_i,
  output logic               pipe_out_valid_o,
  input  logic               pipe_out_ready_i,
  output logic [INSTR_W-1:0] pipe_instr_o,
  output logic [ADDR_W-1:0]  pipe_pc_o,
  output logic [ADDR_W-1:0]  pipe_pc4_o,
  output logic [CNT_W-1:0]   pipe_stall_cnt_o
);

  pipe_state_e        state_q, state_d;
  logic               in_ready, push, pop, out_valid;
  logic               head_ld, skid_ld, head_from_skid;
  logic [INSTR_W-1:0] skid_instr, head_instr_d;
  logic [ADDR_W-1:0]  skid_pc, skid_pc4, head_pc_d, head_pc4_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign out_valid = (state_q != ST_EMPTY);
  assign pop       = out_valid & pipe_out_ready_i;
  assign push      = pipe_in_valid_i & in_ready;

  always_ff @(posedge pipe_clk_i or negedge pipe_rst_n_i) begin
    if (!pipe_rst_n_i) state_q <= ST_EMPTY;
    else               state_q <= state_d;
  end

  // Flush overrides everything: pending input is dropped and head becomes a bubble.
  always_comb begin
    state_d        = state_q;
    head_ld        = 1'b0;
    skid_ld        = 1'b0;
    head_from_skid = 1'b0;
    if (pipe_flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) begin
          head_ld = 1'b1;
          state_d = ST_ONE;
        end
        ST_ONE: begin
          if (push && !pop) begin
            skid_ld = 1'b1;
            state_d = ST_TWO;
          end else if (push && pop) begin
            head_ld = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: if (pop) begin
          head_ld        = 1'b1;
          head_from_skid = 1'b1;
          state_d        = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  generate
    if (SKID) begin : g_skid
      logic in_ready_q;
      always_ff @(posedge pipe_clk_i or negedge pipe_rst_n_i) begin
        if (!pipe_rst_n_i) in_ready_q <= 1'b1;
        else               in_ready_q <= (state_d != ST_TWO);
      end
      assign in_ready = in_ready_q;

      pipe_entry_reg #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_skid (
        .clk_i   (pipe_clk_i),
        .rst_n_i (pipe_rst_n_i),
        .load_i  (skid_ld),
        .bubble_i(pipe_flush_i),
        .instr_i (pipe_instr_i),
        .pc_i    (pipe_pc_i),
        .pc4_i   (pipe_pc4_i),
        .instr_o (skid_instr),
        .pc_o    (skid_pc),
        .pc4_o   (skid_pc4)
      );
    end else begin : g_noskid
      assign in_ready   = !out_valid | pipe_out_ready_i;
      assign skid_instr = '0;
      assign skid_pc    = '0;
      assign skid_pc4   = '0;
    end
  endgenerate

  assign head_instr_d = head_from_skid ? skid_instr : pipe_instr_i;
  assign head_pc_d    = head_from_skid ? skid_pc    : pipe_pc_i;
  assign head_pc4_d   = head_from_skid ? skid_pc4   : pipe_pc4_i;

  pipe_entry_reg #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_head (
    .clk_i   (pipe_clk_i),
    .rst_n_i (pipe_rst_n_i),
    .load_i  (head_ld),
    .bubble_i(pipe_flush_i),
    .instr_i (head_instr_d),
    .pc_i    (head_pc_d),
    .pc4_i   (head_pc4_d),
    .instr_o (pipe_instr_o),
    .pc_o    (pipe_pc_o),
    .pc4_o   (pipe_pc4_o)
  );

  // Counter survives flush; only reset clears it.
  assign cnt_d = (out_valid && !pipe_out_ready_i && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge pipe_clk_i or negedge pipe_rst_n_i) begin
    if (!pipe_rst_n_i) cnt_q <= '0;
    else               cnt_q <= cnt_d;
  end

  assign pipe_in_ready_o  = in_ready;
  assign pipe_out_valid_o = out_valid;
  assign pipe_stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, skid with 4-bit counter, no skid)
// compared every cycle against a count-based FIFO model, plus directed literal checks.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  localparam ent_t BUBBLE = '{instr: 32'h0, pc: 32'h3000, pc4: 32'h3004};

  logic        clk = 1'b0;
  logic        rst_n, flush, iv, ordy;
  logic [31:0] instr_i, pc_i, pc4_i;

  logic        a_ir, a_ov, s_ir, s_ov, z_ir, z_ov;
  logic [31:0] a_instr, a_pc, a_pc4, s_instr, s_pc, s_pc4, z_instr, z_pc, z_pc4;
  logic [15:0] a_cnt, z_cnt;
  logic [3:0]  s_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(1'b1), .CNT_W(16)) u_a (
    .pipe_clk_i(clk), .pipe_rst_n_i(rst_n), .pipe_flush_i(flush),
    .pipe_in_valid_i(iv), .pipe_in_ready_o(a_ir),
    .pipe_instr_i(instr_i), .pipe_pc_i(pc_i), .pipe_pc4_i(pc4_i),
    .pipe_out_valid_o(a_ov), .pipe_out_ready_i(ordy),
    .pipe_instr_o(a_instr), .pipe_pc_o(a_pc), .pipe_pc4_o(a_pc4),
    .pipe_stall_cnt_o(a_cnt));

  pipe_stage_reg #(.SKID(1'b1), .CNT_W(4)) u_s (
    .pipe_clk_i(clk), .pipe_rst_n_i(rst_n), .pipe_flush_i(flush),
    .pipe_in_valid_i(iv), .pipe_in_ready_o(s_ir),
    .pipe_instr_i(instr_i), .pipe_pc_i(pc_i), .pipe_pc4_i(pc4_i),
    .pipe_out_valid_o(s_ov), .pipe_out_ready_i(ordy),
    .pipe_instr_o(s_instr), .pipe_pc_o(s_pc), .pipe_pc4_o(s_pc4),
    .pipe_stall_cnt_o(s_cnt));

  pipe_stage_reg #(.SKID(1'b0), .CNT_W(16)) u_z (
    .pipe_clk_i(clk), .pipe_rst_n_i(rst_n), .pipe_flush_i(flush),
    .pipe_in_valid_i(iv), .pipe_in_ready_o(z_ir),
    .pipe_instr_i(instr_i), .pipe_pc_i(pc_i), .pipe_pc4_i(pc4_i),
    .pipe_out_valid_o(z_ov), .pipe_out_ready_i(ordy),
    .pipe_instr_o(z_instr), .pipe_pc_o(z_pc), .pipe_pc4_o(z_pc4),
    .pipe_stall_cnt_o(z_cnt));

  // Model index 0: capacity-2 stage; index 1: capacity-1 stage.
  int unsigned mn [2];
  ent_t        me [2][2];
  ent_t        shown [2];
  int unsigned mc16 [2];
  int unsigned mc4;

  function automatic bit mrdy(input int m);
    if (m == 0) return mn[0] < 2;
    return (mn[1] == 0) || ordy;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        mn[m] = 0; shown[m] = BUBBLE; mc16[m] = 0;
      end
      mc4 = 0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        bit rdy, pu, po;
        rdy = mrdy(m);
        pu  = iv && rdy;
        po  = (mn[m] > 0) && ordy;
        if (mn[m] > 0 && !ordy) begin
          if (mc16[m] < 65535) mc16[m]++;
          if (m == 0 && mc4 < 15) mc4++;
        end
        if (flush) begin
          mn[m] = 0;
          shown[m] = BUBBLE;
        end else begin
          if (po) begin
            me[m][0] = me[m][1];
            mn[m]--;
          end
          if (pu) begin
            me[m][mn[m]] = '{instr: instr_i, pc: pc_i, pc4: pc4_i};
            mn[m]++;
          end
          if (mn[m] > 0) shown[m] = me[m][0];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_valid", a_ov, mn[0] > 0);
    chk("a_fields", {a_instr, a_pc, a_pc4}, shown[0]);
    chk("a_ready", a_ir, mrdy(0));
    chk("a_cnt", a_cnt, mc16[0][15:0]);
    chk("s_valid", s_ov, mn[0] > 0);
    chk("s_fields", {s_instr, s_pc, s_pc4}, shown[0]);
    chk("s_cnt", s_cnt, mc4[3:0]);
    chk("z_valid", z_ov, mn[1] > 0);
    chk("z_fields", {z_instr, z_pc, z_pc4}, shown[1]);
    chk("z_ready", z_ir, mrdy(1));
    chk("z_cnt", z_cnt, mc16[1][15:0]);
  end

  task automatic drive(input bit v, input bit r, input bit f, input logic [31:0] ins, input logic [31:0] pc);
    iv = v; ordy = r; flush = f; instr_i = ins; pc_i = pc; pc4_i = pc + 32'd4;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 0; iv = 0; ordy = 0; instr_i = 0; pc_i = 0; pc4_i = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Fill to two entries, then reset asynchronously mid-cycle.
    drive(1, 0, 0, 32'h1111_0001, 32'h100);
    drive(1, 0, 0, 32'h1111_0002, 32'h104);
    chk("pre_rst_ready", a_ir, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", a_ov, 1'b0);
    chk("rst_pc", a_pc, 32'h3000);
    chk("rst_pc4", a_pc4, 32'h3004);
    chk("rst_instr", a_instr, 32'h0);
    chk("rst_ready", a_ir, 1'b1);
    chk("rst_cnt", a_cnt, 16'h0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Stream at full rate.
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 0, 32'hA000_0000 + k, 32'h3000 + 4 * k);
      chk("stream_instr", a_instr, 32'hA000_0000 + k);
      chk("stream_valid", a_ov, 1'b1);
    end
    drive(0, 1, 0, 32'h0, 32'h0);

    // Stall with A, B held; input while full is ignored.
    drive(1, 0, 0, 32'hAAAA_AAAA, 32'h200);
    drive(1, 0, 0, 32'hBBBB_BBBB, 32'h204);
    for (int k = 0; k < 4; k++) drive(1, 0, 0, 32'hDEAD_0000 + k, 32'h900);
    chk("stall_cnt", a_cnt, 16'd5);
    chk("stall_ready", a_ir, 1'b0);
    chk("stall_head", a_instr, 32'hAAAA_AAAA);
    drive(0, 1, 0, 32'h0, 32'h0);
    chk("drain_b", a_instr, 32'hBBBB_BBBB);
    chk("drain_b_pc", a_pc, 32'h204);
    drive(0, 1, 0, 32'h0, 32'h0);
    chk("drain_empty", a_ov, 1'b0);
    chk("drain_keep", a_instr, 32'hBBBB_BBBB);

    // Flush while full with a live input.
    drive(1, 0, 0, 32'hCCCC_CCCC, 32'h300);
    drive(1, 0, 0, 32'hDDDD_DDDD, 32'h304);
    drive(1, 1, 1, 32'hEEEE_EEEE, 32'h308);
    chk("flush_valid", a_ov, 1'b0);
    chk("flush_pc", a_pc, 32'h3000);
    chk("flush_instr", a_instr, 32'h0);
    chk("flush_cnt", a_cnt, 16'd6);
    drive(0, 1, 0, 32'h0, 32'h0);
    chk("flush_dropped", a_ov, 1'b0);

    // Counter saturation on the 4-bit instance.
    do_reset();
    drive(1, 0, 0, 32'hF0F0_F0F0, 32'h400);
    repeat (20) drive(0, 0, 0, 32'h0, 32'h0);
    chk("sat_cnt4", s_cnt, 4'hF);
    chk("sat_cnt16", a_cnt, 16'd20);

    // Single-entry variant: combinational ready and same-cycle replace.
    do_reset();
    drive(1, 1, 0, 32'h5555_0001, 32'h500);
    iv = 0; ordy = 0;
    #1 chk("z_ready_fall", z_ir, 1'b0);
    iv = 1; ordy = 1; instr_i = 32'h5555_0002; pc_i = 32'h504; pc4_i = 32'h508;
    #1 chk("z_ready_rise", z_ir, 1'b1);
    @(negedge clk); #1;
    chk("z_replace", z_instr, 32'h5555_0002);
    chk("z_replace_v", z_ov, 1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 79) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
            $urandom, $urandom);
    end
    rst_n = 1'b1;
    drive(0, 1, 0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=%0d exp=0", checks);
    $fatal(1, "timeout");
  end

endmodule
